// File: rtl/tdm_demux.sv
// TDM receive-side demultiplexer: aligns to the frame-sync marker and rebuilds
// one parallel N_CH-word frame per N_CH serial words, flagging alignment errors.
//
// state | meaning
// HUNT  | searching for a SYNC-qualified word to use as slot 0
// LOCK  | aligned; collecting slot words and checking SYNC position
module tdm_demux #(
   parameter int N_CH = 4,
   parameter int DW   = 8
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [DW-1:0]             DIN,
   input  logic                      DIN_VLD,
   input  logic                      SYNC,
   input  logic                      CLR_ERR,
   output logic [N_CH*DW-1:0]        OUT,
   output logic                      OUT_VLD,
   output logic [$clog2(N_CH)-1:0]   SLOT,
   output logic                      LOCKED,
   output logic                      ERR
);

   localparam int SW = $clog2(N_CH);
   localparam logic [SW-1:0] SLOT_LAST = SW'(N_CH - 1);

   typedef enum logic {HUNT, LOCK} state_t;

   state_t              state, state_nxt;
   logic [SW-1:0]       slot, slot_nxt;
   logic [DW-1:0]       sh [0:N_CH-2];
   logic [SW-1:0]       wr_idx;
   logic                sh_wr;
   logic                done;
   logic                err_set;
   logic [N_CH*DW-1:0]  frame;

   always_comb begin
      state_nxt = state;
      slot_nxt  = slot;
      sh_wr     = 1'b0;
      wr_idx    = slot;
      done      = 1'b0;
      err_set   = 1'b0;
      case (state)
         HUNT: begin
            if (DIN_VLD && SYNC) begin
               sh_wr     = 1'b1;
               wr_idx    = '0;
               slot_nxt  = SW'(1);
               state_nxt = LOCK;
            end
         end
         LOCK: begin
            if (DIN_VLD) begin
               if (SYNC) begin
                  // An early SYNC drops the partial frame and restarts at slot 0.
                  err_set  = (slot != '0);
                  sh_wr    = 1'b1;
                  wr_idx   = '0;
                  slot_nxt = SW'(1);
               end else if (slot == '0) begin
                  err_set   = 1'b1;
                  slot_nxt  = '0;
                  state_nxt = HUNT;
               end else if (slot == SLOT_LAST) begin
                  done     = 1'b1;
                  slot_nxt = '0;
               end else begin
                  sh_wr    = 1'b1;
                  slot_nxt = slot + SW'(1);
               end
            end
         end
         default: state_nxt = HUNT;
      endcase
   end

   // Last channel is taken straight from DIN so no shadow is needed for it.
   always_comb begin
      frame = '0;
      for (int k = 0; k < N_CH - 1; k++) begin
         frame[k*DW +: DW] = sh[k];
      end
      frame[(N_CH-1)*DW +: DW] = DIN;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state   <= HUNT;
         slot    <= '0;
         OUT     <= '0;
         OUT_VLD <= 1'b0;
         ERR     <= 1'b0;
         for (int k = 0; k < N_CH - 1; k++) begin
            sh[k] <= '0;
         end
      end else begin
         state   <= state_nxt;
         slot    <= slot_nxt;
         OUT_VLD <= done;
         if (done) begin
            OUT <= frame;
         end
         if (err_set) begin
            ERR <= 1'b1;
         end else if (CLR_ERR) begin
            ERR <= 1'b0;
         end
         for (int k = 0; k < N_CH - 1; k++) begin
            if (sh_wr && wr_idx == SW'(k)) begin
               sh[k] <= DIN;
            end
         end
      end
   end

   assign SLOT   = slot;
   assign LOCKED = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N_CH=4, DW=8): per-cycle vector table plus a
// hand-written ERR set/clear collision sequence.
module tb_tdm_demux;

   logic        CLK;
   logic        RST_N;
   logic [7:0]  DIN;
   logic        DIN_VLD;
   logic        SYNC;
   logic        CLR_ERR;
   logic [31:0] OUT;
   logic        OUT_VLD;
   logic [1:0]  SLOT;
   logic        LOCKED;
   logic        ERR;

   int checks = 0;
   int errors = 0;

   tdm_demux #(.N_CH(4), .DW(8)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .DIN     (DIN),
      .DIN_VLD (DIN_VLD),
      .SYNC    (SYNC),
      .CLR_ERR (CLR_ERR),
      .OUT     (OUT),
      .OUT_VLD (OUT_VLD),
      .SLOT    (SLOT),
      .LOCKED  (LOCKED),
      .ERR     (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst_n;
      logic        vld;
      logic        sync;
      logic        clr;
      logic [7:0]  din;
      logic [31:0] out;
      logic        ovld;
      logic [1:0]  slot;
      logic        lock;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst_n, logic vld, logic sync, logic clr,
                               logic [7:0] din, logic [31:0] out, logic ovld,
                               logic [1:0] slot, logic lock, logic err);
      vec_t v;
      v.rst_n = rst_n; v.vld = vld; v.sync = sync; v.clr = clr; v.din = din;
      v.out = out; v.ovld = ovld; v.slot = slot; v.lock = lock; v.err = err;
      return v;
   endfunction

   task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic apply(vec_t v, int idx);
      @(negedge CLK);
      RST_N   = v.rst_n;
      DIN_VLD = v.vld;
      SYNC    = v.sync;
      CLR_ERR = v.clr;
      DIN     = v.din;
      @(posedge CLK);
      #1;
      chk("out",     idx, OUT,             v.out);
      chk("out_vld", idx, 32'(OUT_VLD),    32'(v.ovld));
      chk("slot",    idx, 32'(SLOT),       32'(v.slot));
      chk("locked",  idx, 32'(LOCKED),     32'(v.lock));
      chk("err",     idx, 32'(ERR),        32'(v.err));
   endtask

   initial begin
      RST_N = 1'b0; DIN = '0; DIN_VLD = 1'b0; SYNC = 1'b0; CLR_ERR = 1'b0;

      //          rst vld syn clr din    out          ovld slot lock err
      vecs.push_back(mk(0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0));
      // back-to-back frame
      vecs.push_back(mk(1, 1, 1, 0, 8'h11, 32'h0,        0, 1, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 8'h22, 32'h0,        0, 2, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 8'h33, 32'h0,        0, 3, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 8'h44, 32'h44332211, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 8'h00, 32'h44332211, 0, 0, 1, 0));
      // frame with valid gaps of 1, 2, 3 cycles; junk on DIN/SYNC during gaps
      vecs.push_back(mk(1, 1, 1, 0, 8'h55, 32'h44332211, 0, 1, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0, 8'hEE, 32'h44332211, 0, 1, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 8'h66, 32'h44332211, 0, 2, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 8'hEE, 32'h44332211, 0, 2, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0, 8'hEE, 32'h44332211, 0, 2, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 8'h77, 32'h44332211, 0, 3, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 8'hEE, 32'h44332211, 0, 3, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 8'hEE, 32'h44332211, 0, 3, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0, 8'hEE, 32'h44332211, 0, 3, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 8'h88, 32'h88776655, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 8'h00, 32'h88776655, 0, 0, 1, 0));
      // early sync
      vecs.push_back(mk(1, 1, 1, 0, 8'hA1, 32'h88776655, 0, 1, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 8'hA2, 32'h88776655, 0, 2, 1, 0));
      vecs.push_back(mk(1, 1, 1, 0, 8'hB1, 32'h88776655, 0, 1, 1, 1));
      vecs.push_back(mk(1, 1, 0, 0, 8'hB2, 32'h88776655, 0, 2, 1, 1));
      vecs.push_back(mk(1, 1, 0, 0, 8'hB3, 32'h88776655, 0, 3, 1, 1));
      vecs.push_back(mk(1, 1, 0, 0, 8'hB4, 32'hB4B3B2B1, 1, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 1, 8'h00, 32'hB4B3B2B1, 0, 0, 1, 0));
      // missing sync, hunt, relock
      vecs.push_back(mk(1, 1, 0, 0, 8'h99, 32'hB4B3B2B1, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 0, 0, 8'h01, 32'hB4B3B2B1, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 0, 0, 8'h02, 32'hB4B3B2B1, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 1, 0, 8'h10, 32'hB4B3B2B1, 0, 1, 1, 1));
      vecs.push_back(mk(1, 1, 0, 0, 8'h20, 32'hB4B3B2B1, 0, 2, 1, 1));
      vecs.push_back(mk(1, 1, 0, 0, 8'h30, 32'hB4B3B2B1, 0, 3, 1, 1));
      vecs.push_back(mk(1, 1, 0, 0, 8'h40, 32'h40302010, 1, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 0, 8'h00, 32'h40302010, 0, 0, 1, 1));
      // mid-frame reset with a valid word on the reset edge
      vecs.push_back(mk(1, 1, 1, 0, 8'hC1, 32'h40302010, 0, 1, 1, 1));
      vecs.push_back(mk(1, 1, 0, 0, 8'hC2, 32'h40302010, 0, 2, 1, 1));
      vecs.push_back(mk(0, 1, 1, 0, 8'hC3, 32'h0,        0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 8'hC4, 32'h0,        0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 8'hD1, 32'h0,        0, 1, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 8'hD2, 32'h0,        0, 2, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 8'hD3, 32'h0,        0, 3, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 8'hD4, 32'hD4D3D2D1, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 8'h00, 32'hD4D3D2D1, 0, 0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], i);
      end

      // ERR set and clear on the same edge: set wins; clear alone then works
      apply(mk(1, 1, 1, 0, 8'hE1, 32'hD4D3D2D1, 0, 1, 1, 0), 100);
      apply(mk(1, 1, 1, 0, 8'hE2, 32'hD4D3D2D1, 0, 1, 1, 1), 101);
      apply(mk(1, 1, 0, 0, 8'hE3, 32'hD4D3D2D1, 0, 2, 1, 1), 102);
      apply(mk(1, 1, 1, 1, 8'hF1, 32'hD4D3D2D1, 0, 1, 1, 1), 103);
      apply(mk(1, 0, 0, 1, 8'h00, 32'hD4D3D2D1, 0, 1, 1, 0), 104);
      apply(mk(1, 1, 0, 0, 8'hF2, 32'hD4D3D2D1, 0, 2, 1, 0), 105);
      apply(mk(1, 1, 0, 0, 8'hF3, 32'hD4D3D2D1, 0, 3, 1, 0), 106);
      apply(mk(1, 1, 0, 0, 8'hF4, 32'hF4F3F2F1, 1, 0, 1, 0), 107);
      apply(mk(1, 0, 0, 0, 8'h00, 32'hF4F3F2F1, 0, 0, 1, 0), 108);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: receives a serial word stream carrying N_CH channels in fixed slot order and rebuilds one parallel frame per N_CH words.
- Sits at the receive end of the TDM link. It performs the inverse of the selector-based TDM mux stage.
- Uses a frame-sync marker for slot alignment. Detects misalignment, resynchronises, and reports errors with a sticky flag.

Parameters:
- N_CH, 4, number of channels per frame; legal range 2..16.
- DW, 8, data width of each channel word.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  synchronous reset, active-low.
- DIN  in  DW  incoming TDM word.
- DIN_VLD  in  1  DIN valid this cycle; DIN and SYNC are ignored when low.
- SYNC  in  1  qualified by DIN_VLD; marks the current word as slot 0.
- CLR_ERR  in  1  clears ERR on the next edge.
- OUT  out  N_CH*DW  last complete frame; channel k occupies bits [k*DW +: DW].
- OUT_VLD  out  1  one-cycle pulse when OUT is updated.
- SLOT  out  clog2(N_CH)  slot index expected for the next valid word.
- LOCKED  out  1  high while in the LOCK state.
- ERR  out  1  sticky alignment-error flag.

Behaviour:
- Reset: when RST_N=0 at an edge, set OUT=0, OUT_VLD=0, SLOT=0, LOCKED=0, ERR=0, all shadow registers=0, state=HUNT. Reset has priority over every other input, including mid-frame.
- Internal storage: shadow registers SH[0..N_CH-2], each DW wide.
- State HUNT:
  - Words without SYNC are discarded.
  - DIN_VLD=1 and SYNC=1: SH[0]<=DIN, SLOT<=1, go to LOCK.
- State LOCK, on each DIN_VLD=1:
  - SYNC=1 and SLOT==0: normal frame start; SH[0]<=DIN, SLOT<=1.
  - SYNC=0 and SLOT==0: missing sync. Set ERR=1, discard the word, SLOT<=0, go to HUNT.
  - SYNC=1 and SLOT!=0: early sync. Set ERR=1, discard the partial frame (OUT unchanged, no pulse), SH[0]<=DIN, SLOT<=1, stay in LOCK.
  - SYNC=0 and 0<SLOT<N_CH-1: SH[SLOT]<=DIN, SLOT<=SLOT+1.
  - SYNC=0 and SLOT==N_CH-1 (frame completion):
    - OUT<={DIN, SH[N_CH-2], ..., SH[0]}, i.e. channel N_CH-1 takes DIN directly.
    - OUT_VLD<=1 for exactly one cycle.
    - SLOT wraps to 0.
- Timing:
  - Latency: OUT and OUT_VLD are valid in the cycle after the edge that samples the last slot word.
  - OUT holds its value until the next completed frame.
  - DIN_VLD gaps are allowed anywhere; SLOT and the shadow registers hold during gaps.
- LOCKED equals (state==LOCK) and is registered.
- SLOT reads 0 in HUNT.
- ERR:
  - Set on any alignment error.
  - CLR_ERR=1 clears it.
  - If a set and a clear occur on the same edge, the set wins.
  - ERR has no other effect on operation.
- OUT_VLD is 0 in every cycle not immediately following a frame completion.

Test Plan (N_CH=4, DW=8):
1. Reset, then 4 consecutive valid words 0x11(SYNC), 0x22, 0x33, 0x44 → LOCKED=1 after the first word; one cycle after 0x44, OUT=0x44332211 and OUT_VLD=1 for exactly 1 cycle; ERR=0.
2. Words 0x55(SYNC), 0x66, 0x77, 0x88 sent with DIN_VLD=0 gaps of 0–3 cycles between words → a single OUT_VLD pulse, OUT=0x88776655; SLOT holds its value across the gaps.
3. Locked; send 0xA1(SYNC), 0xA2, then 0xB1(SYNC), 0xB2, 0xB3, 0xB4 → ERR=1 at the edge that samples 0xB1; no pulse for the A frame; one pulse later with OUT=0xB4B3B2B1.
4. Locked at SLOT=0; send 0x99 with SYNC=0 → ERR=1, LOCKED=0, OUT unchanged. Then 0x01, 0x02 without SYNC → ignored. Then 0x10(SYNC), 0x20, 0x30, 0x40 → relock and OUT=0x40302010.
5. Assert RST_N=0 after 2 words of a frame, then release and send a full SYNC frame → all outputs are 0 during reset; the first pulse afterwards carries only the new frame; no stale shadow data appears.
6. With ERR=1, assert CLR_ERR on the same edge as an early-sync error → ERR stays 1. Assert CLR_ERR alone → ERR=0 on the next cycle.
